// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: the core pushes bytes with a strobe,
// and the peripheral reports its FIFO and line status back.
interface uart_tx_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       overflow;
  logic       tx;

  // Core side: offers bytes, observes status and the serial line.
  modport master (
    output wr_en, wr_data,
    input  full, busy, overflow, tx
  );

  // Peripheral side.
  modport slave (
    input  wr_en, wr_data,
    output full, busy, overflow, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes written by the core land in a small
// circular FIFO; the transmit FSM pops them one at a time and shifts each out
// LSB first, framed by a low start bit and a high stop bit, CLK_DIV clocks per
// bit. Frames queued back-to-back follow each other with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_DIV = 16,
  parameter int DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q;
  logic          overflow_q;

  logic          full;
  logic          pop;
  logic          wr_acc;
  logic          baud_end;

  assign full     = (count_q == FULL_CNT);
  assign baud_end = (baud_q == BAUD_LAST);
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign wr_acc   = bus.wr_en && (!full || pop);

  assign bus.full     = full;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.tx       = tx_q;

  // FIFO occupancy after this edge's write and pop.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM: next state, line level, bit timing and the pop decision.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
        end
      end

      START: begin
        if (baud_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = 3'd0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (count_q != '0) begin
            // Next byte already waiting: start its frame without an idle bit.
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; an entry is only read after it was
    // written, so clearing it would cost logic and buy nothing.
    if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
  end

  // Control and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      state_q    <= state_d;
      count_q    <= count_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != IDLE) || (count_d != '0);
      overflow_q <= overflow_q | (bus.wr_en & ~wr_acc);
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLK_DIV=4, DEPTH=4. A queue-based
// model predicts the line and status every cycle; a line decoder recovers the
// transmitted bytes; directed scenarios pin the model with literal values.
module tb_uart_tx_fifo;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq holds bytes waiting in the FIFO; pos is the cycle index inside the
  // frame currently on the line (-1 when the line is idle).
  logic [7:0] mq[$];
  logic [7:0] acc_log[$];
  int         pos   = -1;
  logic [7:0] cur   = 8'h00;
  logic       m_ovf = 1'b0;

  initial begin
    bit can_pop, wr_ok;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        pos   = -1;
        m_ovf = 1'b0;
      end else begin
        can_pop = ((pos < 0) || (pos == FRAME - 1)) && (mq.size() > 0);
        wr_ok   = bus.wr_en && ((mq.size() < DEPTH) || can_pop);
        if (bus.wr_en && !wr_ok) m_ovf = 1'b1;
        if (can_pop) begin
          cur = mq.pop_front();
          pos = 0;
        end else if (pos == FRAME - 1) begin
          pos = -1;
        end else if (pos >= 0) begin
          pos++;
        end
        if (wr_ok) begin
          mq.push_back(bus.wr_data);
          acc_log.push_back(bus.wr_data);
        end
      end
    end
  end

  function automatic logic exp_tx();
    logic [9:0] f;
    if (pos < 0) return 1'b1;
    f = {1'b1, cur, 1'b0};
    return f[pos / CLK_DIV];
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("tx",       bus.tx,       exp_tx());
      check("busy",     bus.busy,     (pos >= 0) || (mq.size() > 0));
      check("full",     bus.full,     mq.size() == DEPTH);
      check("overflow", bus.overflow, m_ovf);
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rxq[$];
  int         rx_j = -1;

  initial begin
    logic [7:0] sh;
    sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rx_j = -1;
      end else begin
        if (rx_j < 0) begin
          if (bus.tx == 1'b0) rx_j = 0;
        end else begin
          rx_j++;
        end
        if (rx_j >= 0) begin
          if (rx_j >= CLK_DIV && rx_j < 9 * CLK_DIV && (rx_j % CLK_DIV) == CLK_DIV / 2)
            sh[rx_j / CLK_DIV - 1] = bus.tx;
          if (rx_j == 9 * CLK_DIV + CLK_DIV / 2)
            check("stop_bit", bus.tx, 1'b1);
          if (rx_j == FRAME - 1) begin
            rxq.push_back(sh);
            rx_j = -1;
          end
        end
      end
    end
  end

  function automatic logic [8:0] rx_at(input int i);
    if (i < rxq.size()) return {1'b0, rxq[i]};
    return 9'h100;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    rxq.delete();
    acc_log.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_pos(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (pos != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, n < budget, 1'b1);
  endtask

  task automatic idle_window(input string name, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random scenarios ----------------
  initial begin
    logic [79:0] cap;
    logic        busy_all;
    int          rate;

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    #1 rst = 1'b0;
    #1;
    check("rst_tx",       bus.tx,       1'b1);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_full",     bus.full,     1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Quiet line after reset.
    idle_window("idle_100", 100);

    // Single byte 0xA5.
    rxq.delete();
    @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    @(negedge clk); bus.wr_en = 1'b0;
    cap = '0; busy_all = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      cap[i]   = bus.tx;
      busy_all = busy_all & bus.busy;
    end
    check("a5_line",     cap,      80'hFF0F00F0F0);
    check("a5_busy",     busy_all, 1'b1);
    @(negedge clk);
    check("a5_busy_end", bus.busy, 1'b0);
    check("a5_rx",       rx_at(0), 9'h0A5);

    // Back-to-back 0x00 then 0xFF.
    rxq.delete();
    @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h00;
    @(negedge clk); bus.wr_data = 8'hFF;
    cap = '0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (i == 0) bus.wr_en = 1'b0;
      cap[i] = bus.tx;
    end
    check("b2b_line", cap, 80'hFFFFFFFFF0F000000000);
    wait_idle("b2b_idle", 50);
    check("b2b_rx_n", rxq.size(), 2);

    // Six writes into a four-entry FIFO: last one dropped.
    rxq.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("ovf_full_after_14", bus.full,     1'b1);
        check("ovf_not_yet",       bus.overflow, 1'b0);
      end
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk); bus.wr_en = 1'b0;
    check("ovf_set", bus.overflow, 1'b1);
    wait_idle("ovf_idle", 6 * FRAME);
    check("ovf_rx_n", rxq.size(), 5);
    for (int i = 0; i < 5; i++) check("ovf_rx_byte", rx_at(i), {1'b0, 8'h10 + 8'(i)});
    check("ovf_sticky", bus.overflow, 1'b1);

    // Write into a full FIFO on the cycle the stop bit ends and pops.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'hC0 + 8'(i);
    end
    @(negedge clk); bus.wr_en = 1'b0;
    wait_pos("pop_wait", FRAME - 1, 2 * FRAME);
    check("pop_full_before", bus.full, 1'b1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h3C;
    @(negedge clk); bus.wr_en = 1'b0;
    check("pop_full_after", bus.full,     1'b1);
    check("pop_no_ovf",     bus.overflow, 1'b0);
    wait_idle("pop_idle", 8 * FRAME);
    check("pop_rx_n",    rxq.size(), 6);
    check("pop_rx_last", rx_at(5),   9'h03C);
    check("pop_rx_first", rx_at(0),  9'h0C0);

    // Reset in the middle of the data bits with two bytes queued.
    do_reset();
    @(negedge clk); bus.wr_en = 1'b1; bus.wr_data = 8'h5A;
    @(negedge clk); bus.wr_data = 8'hA1;
    @(negedge clk); bus.wr_data = 8'hB2;
    @(negedge clk); bus.wr_en = 1'b0;
    wait_pos("mid_wait", 5 * CLK_DIV, 2 * FRAME);
    #2 rst = 1'b0;
    #1;
    check("mid_tx",   bus.tx,   1'b1);
    check("mid_busy", bus.busy, 1'b0);
    check("mid_full", bus.full, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    rxq.delete();
    acc_log.delete();
    idle_window("mid_quiet", 100);
    check("mid_rx_n", rxq.size(), 0);

    // Randomised traffic at several write densities.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      rate = (blk % 3 == 0) ? 3 : (blk % 3 == 1) ? 15 : 70;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        bus.wr_en   = ($urandom_range(0, 99) < rate);
        bus.wr_data = 8'($urandom);
      end
    end
    @(negedge clk); bus.wr_en = 1'b0;
    wait_idle("rnd_idle", (DEPTH + 2) * FRAME);
    check("rnd_rx_n", rxq.size(), acc_log.size());
    for (int i = 0; i < acc_log.size(); i++)
      check("rnd_rx_byte", rx_at(i), {1'b0, acc_log[i]});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Output-side peripheral downstream of the CPU core: takes bytes the core presents on its 8-bit output bus with a write strobe.
- Buffers them in a small circular FIFO and serialises each byte as a standard 8N1 asynchronous frame on a single line.
- Lets the core emit bytes at full clock rate without stalling, until the FIFO fills.

Parameters:
- CLK_DIV, 16, clock cycles per serial bit; integer >= 2.
- DEPTH, 4, FIFO entries; power of two >= 2.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe; byte on wr_data offered this cycle.
- wr_data  input  8  byte to transmit (from core out_data).
- full  output  1  combinational, count == DEPTH.
- busy  output  1  registered; state != IDLE or FIFO non-empty.
- overflow  output  1  sticky; a write was dropped; cleared only by reset.
- tx  output  1  registered serial line; idle high.

Behaviour:
- Reset (rst low, async):
  - tx=1, busy=0, overflow=0, full=0.
  - count=0, read and write pointers=0, state=IDLE, bit/baud counters=0.
  - FIFO contents are don't-care.
  - Reset mid-frame aborts the frame immediately: tx returns high and all queued bytes are discarded.
- FIFO:
  - Circular buffer; pointers are log2(DEPTH) bits and wrap naturally.
  - Count range is 0..DEPTH.
  - A write is accepted iff wr_en && (!full || pop_this_cycle).
  - Accepted write stores at wr_ptr, then wr_ptr+1.
  - wr_en && full && !pop: byte dropped, overflow<=1, pointers and count unchanged.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
- Tx FSM (states IDLE, START, DATA, STOP):
  - IDLE: tx=1. If count>0 at a rising edge: pop head into shift register, rd_ptr+1, state<=START, tx<=0, baud counter<=0.
  - START: hold tx=0 for CLK_DIV cycles, then state<=DATA, tx<=shift[0], bit index 0.
  - DATA:
    - Each bit is held CLK_DIV cycles, LSB first.
    - After bit 7: state<=STOP, tx<=1.
  - STOP: hold tx=1 for CLK_DIV cycles. At the end:
    - If count>0: pop and go directly to START (tx<=0); back-to-back frames, no idle gap.
    - Otherwise: state<=IDLE.
  - The pop decision uses pre-edge count. A byte written in the same cycle as the IDLE check is not visible until the next edge.
- Latency and timing:
  - Write accepted at edge k into an empty FIFO in IDLE: pop at edge k+1, tx low from edge k+1.
  - Frame length is exactly 10*CLK_DIV cycles.
  - Sustained throughput is one byte per 10*CLK_DIV cycles.
- Counters: baud counter width is ceil(log2(CLK_DIV)) and counts 0..CLK_DIV-1; bit index is 3 bits.
- Busy: busy deasserts on the edge that enters IDLE with an empty FIFO.

Test Plan:
- CLK_DIV=4. Write 0xA5 once, idle FIFO:
  - tx low from edge after write for 4 cycles.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; 40 cycles total.
  - busy=1 throughout and 0 after.
- Write 0x00 then 0xFF on consecutive cycles:
  - Two frames back-to-back; second start bit begins the cycle after the first stop bit's 4th cycle, no gap.
  - Line reads 0,00000000,1,0,11111111,1.
- DEPTH=4, write 0x10..0x15 on six consecutive cycles:
  - 0x10 popped on cycle 2; FIFO full after 0x14; 0x15 dropped, overflow=1.
  - Exactly five frames 0x10..0x14 emitted; overflow stays 1.
- FIFO full, mid-frame. Assert wr_en with 0x3C on the exact cycle STOP ends and pops:
  - Write accepted, full stays 1, overflow stays 0.
  - 0x3C is transmitted last.
- Reset mid-DATA (after bit 3 of 0x5A) with two bytes queued:
  - tx=1, busy=0, full=0 immediately (async).
  - After release, no frame is emitted without a new write.
- No writes for 100 cycles after reset: tx=1, busy=0, overflow=0 constantly.
